// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry instruction queue: owns the fetch PC, issues
// sequential ibus requests, buffers responses and drains them to decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ireq_valid,
    output logic [63:0]              ireq_addr,
    input  logic                     iresp_data_ok,
    input  logic [31:0]              iresp_data,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data_pc,
    output logic [31:0]              out_data_instr,
    output logic                     out_data_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     imem_wait
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t             state_reg, state_next;
    logic [63:0]        fetch_pc_reg, fetch_pc_next;
    logic [63:0]        discard_addr_reg, discard_addr_next;
    logic [PTR_W-1:0]   head_reg, head_next;
    logic [PTR_W-1:0]   tail_reg, tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [63:0]        pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];

    logic push, pop;

    // Asynchronous head read: a response sampled at edge N must be visible at cycle N+1.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PTR_W'(gi))) begin
                    pc_mem[gi]    <= fetch_pc_reg;
                    instr_mem[gi] <= iresp_data;
                end
            end
        end
    endgenerate

    always_comb begin
        ireq_valid = 1'b0;
        ireq_addr  = '0;
        if (reset) begin
            if (state_reg == DISCARD) begin
                ireq_valid = 1'b1;
                ireq_addr  = discard_addr_reg;
            end else begin
                ireq_valid = (count_reg < CNT_W'(DEPTH)) && (fetch_pc_reg != '0);
                ireq_addr  = fetch_pc_reg;
            end
        end
    end

    assign push = (state_reg == FETCH) && ireq_valid && iresp_data_ok && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    always_comb begin
        state_next        = state_reg;
        fetch_pc_next     = fetch_pc_reg;
        discard_addr_next = discard_addr_reg;
        head_next         = head_reg;
        tail_next         = tail_reg;
        count_next        = count_reg;
        if (redirect) begin
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
            fetch_pc_next = redirect_pc;
            if (state_reg == FETCH) begin
                // An accepted-but-unanswered request must still be held until its data_ok.
                if (ireq_valid && !iresp_data_ok) begin
                    discard_addr_next = ireq_addr;
                    state_next        = DISCARD;
                end
            end else if (iresp_data_ok) begin
                state_next = FETCH;
            end
        end else begin
            if ((state_reg == DISCARD) && iresp_data_ok)
                state_next = FETCH;
            if (push) begin
                tail_next     = tail_reg + PTR_W'(1);
                fetch_pc_next = fetch_pc_reg + 64'd4;
            end
            if (pop)
                head_next = head_reg + PTR_W'(1);
            if (push && !pop)
                count_next = count_reg + CNT_W'(1);
            else if (pop && !push)
                count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= FETCH;
            fetch_pc_reg     <= RESET_PC;
            discard_addr_reg <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            fetch_pc_reg     <= fetch_pc_next;
            discard_addr_reg <= discard_addr_next;
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
        end
    end

    assign count          = count_reg;
    assign out_valid      = (count_reg != '0);
    assign out_data_valid = out_valid;
    assign out_data_pc    = out_valid ? pc_mem[head_reg]    : '0;
    assign out_data_instr = out_valid ? instr_mem[head_reg] : '0;

    always_comb begin
        imem_wait = 1'b0;
        if (reset) begin
            if (state_reg == DISCARD)
                imem_wait = (count_reg == '0);
            else
                imem_wait = ireq_valid && !iresp_data_ok && (count_reg == '0);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): hand-computed expectations checked
// with immediate assertions one cycle step at a time.
module tb_fetch_queue;
    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data_pc;
    logic [31:0] out_data_instr;
    logic        out_data_valid;
    logic [2:0]  count;
    logic        imem_wait;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data_pc    (out_data_pc),
        .out_data_instr (out_data_instr),
        .out_data_valid (out_data_valid),
        .count          (count),
        .imem_wait      (imem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-16s obs=%h exp=%h", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        iresp_data_ok = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_data_pc, 64'd0);
        chk("rst_imem_wait", 64'(imem_wait), 64'd0);
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);

        // Zero-wait bus with decode popping every cycle.
        reset = 1'b1;
        #1;
        chk("first_req_valid", 64'(ireq_valid), 64'd1);
        chk("first_req_addr", ireq_addr, 64'h8000_0000);
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_0000;
        tick();
        chk("zw_out_pc0", out_data_pc, 64'h8000_0000);
        chk("zw_instr0", 64'(out_data_instr), 64'hC0DE_0000);
        chk("zw_entry_valid", 64'(out_data_valid), 64'd1);
        chk("zw_addr1", ireq_addr, 64'h8000_0004);
        for (int i = 1; i < 4; i++) begin
            iresp_data = 32'hC0DE_0000 + 32'(4 * i);
            tick();
            chk("zw_out_pc", out_data_pc, 64'h8000_0000 + 64'(4 * i));
            chk("zw_count", 64'(count), 64'd1);
            chk("zw_addr", ireq_addr, 64'h8000_0000 + 64'(4 * (i + 1)));
        end

        // Fill to DEPTH with decode stalled.
        do_reset();
        out_ready = 1'b0;
        iresp_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iresp_data = 32'hC0DE_0000 + 32'(4 * i);
            tick();
        end
        iresp_data_ok = 1'b0;
        chk("full_count", 64'(count), 64'd4);
        chk("full_req_valid", 64'(ireq_valid), 64'd0);
        chk("full_head_pc", out_data_pc, 64'h8000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count", 64'(count), 64'd3);
        chk("pop_req_valid", 64'(ireq_valid), 64'd1);
        chk("pop_req_addr", ireq_addr, 64'h8000_0010);
        chk("pop_next_pc", out_data_pc, 64'h8000_0004);

        // Drain, then a 3-cycle response latency on the 0x10 request.
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("lat_count", 64'(count), 64'd0);
        chk("lat_wait1", 64'(imem_wait), 64'd1);
        chk("lat_addr1", ireq_addr, 64'h8000_0010);
        tick();
        chk("lat_wait2", 64'(imem_wait), 64'd1);
        chk("lat_addr2", ireq_addr, 64'h8000_0010);
        tick();
        chk("lat_addr3", ireq_addr, 64'h8000_0010);
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_0010;
        #1;
        chk("lat_wait_dok", 64'(imem_wait), 64'd0);
        tick();
        iresp_data_ok = 1'b0;
        chk("lat_out_pc", out_data_pc, 64'h8000_0010);
        chk("lat_instr", 64'(out_data_instr), 64'hC0DE_0010);
        chk("lat_next_addr", ireq_addr, 64'h8000_0014);

        // Second entry, then redirect as the in-flight request completes.
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_0014;
        tick();
        chk("two_count", 64'(count), 64'd2);
        redirect = 1'b1;
        redirect_pc = 64'h8000_1000;
        iresp_data = 32'hDEAD_0018;
        tick();
        redirect = 1'b0;
        iresp_data_ok = 1'b0;
        chk("rd_count", 64'(count), 64'd0);
        chk("rd_out_valid", 64'(out_valid), 64'd0);
        chk("rd_out_pc", out_data_pc, 64'd0);
        chk("rd_req_valid", 64'(ireq_valid), 64'd1);
        chk("rd_req_addr", ireq_addr, 64'h8000_1000);
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_1000;
        tick();
        iresp_data_ok = 1'b0;
        chk("rd_first_pc", out_data_pc, 64'h8000_1000);
        chk("rd_first_cnt", 64'(count), 64'd1);

        // Redirect while the 0x08 request is pending: discard path.
        do_reset();
        out_ready = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_0000;
        tick();
        iresp_data = 32'hC0DE_0004;
        tick();
        iresp_data_ok = 1'b0;
        tick();
        chk("ds_pending_addr", ireq_addr, 64'h8000_0008);
        chk("ds_pending_cnt", 64'(count), 64'd0);
        redirect = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        redirect = 1'b0;
        chk("ds_hold_valid", 64'(ireq_valid), 64'd1);
        chk("ds_hold_addr1", ireq_addr, 64'h8000_0008);
        chk("ds_imem_wait", 64'(imem_wait), 64'd1);
        tick();
        chk("ds_hold_addr2", ireq_addr, 64'h8000_0008);
        redirect = 1'b1;
        redirect_pc = 64'h8000_2000;
        tick();
        redirect = 1'b0;
        chk("ds_hold_addr3", ireq_addr, 64'h8000_0008);
        iresp_data_ok = 1'b1;
        iresp_data = 32'hDEAD_0008;
        tick();
        iresp_data_ok = 1'b0;
        chk("ds_dropped", 64'(out_valid), 64'd0);
        chk("ds_dropped_cnt", 64'(count), 64'd0);
        chk("ds_new_valid", 64'(ireq_valid), 64'd1);
        chk("ds_new_addr", ireq_addr, 64'h8000_2000);
        iresp_data_ok = 1'b1;
        iresp_data = 32'hC0DE_2000;
        tick();
        iresp_data_ok = 1'b0;
        chk("ds_out_pc", out_data_pc, 64'h8000_2000);
        chk("ds_out_instr", 64'(out_data_instr), 64'hC0DE_2000);

        // Redirect to PC 0 halts fetch until the next redirect.
        redirect = 1'b1;
        redirect_pc = 64'd0;
        iresp_data_ok = 1'b1;
        iresp_data = 32'hDEAD_2004;
        tick();
        redirect = 1'b0;
        iresp_data_ok = 1'b0;
        chk("halt_valid1", 64'(ireq_valid), 64'd0);
        tick();
        tick();
        tick();
        chk("halt_valid2", 64'(ireq_valid), 64'd0);
        chk("halt_count", 64'(count), 64'd0);
        chk("halt_wait", 64'(imem_wait), 64'd0);
        redirect = 1'b1;
        redirect_pc = 64'h8000_3000;
        tick();
        redirect = 1'b0;
        chk("unhalt_valid", 64'(ireq_valid), 64'd1);
        chk("unhalt_addr", ireq_addr, 64'h8000_3000);

        // Reset in the middle of a discard abandons it.
        redirect = 1'b1;
        redirect_pc = 64'h8000_4000;
        tick();
        redirect = 1'b0;
        chk("mid_ds_addr", ireq_addr, 64'h8000_3000);
        reset = 1'b0;
        #1;
        chk("in_rst_valid", 64'(ireq_valid), 64'd0);
        do_reset();
        chk("post_rst_valid", 64'(ireq_valid), 64'd1);
        chk("post_rst_addr", ireq_addr, 64'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-entry fetch stage. It owns the fetch PC, issues sequential instruction requests on the ibus, and buffers returned instructions in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from execute flushes the queue and restarts fetch. A response that is still in flight when the redirect arrives is discarded safely, without violating the bus hold rule.

## Interface
- DEPTH, 4: number of queue entries; power of two, ≥2.
- RESET_PC, 64'h8000_0000: fetch PC loaded at reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- ireq  out  ibus_req_t  instruction bus request (valid, addr).
- iresp  in  ibus_resp_t  instruction bus response; only data_ok and data are used.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_data  out  fetch_data_t  head entry {pc, raw_instr, valid}; valid mirrors out_valid.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- imem_wait  out  1  decode is starved by memory.

## Operation
- State registers:
  - state ∈ {FETCH, DISCARD}
  - fetch_pc (64)
  - discard_addr (64)
  - head/tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count
- Request rules:
  - In FETCH: ireq.valid = (count < DEPTH) && (fetch_pc != 0); ireq.addr = fetch_pc.
  - fetch_pc == 0 means halted. No request is issued.
  - In DISCARD: ireq.valid = 1; ireq.addr = discard_addr.
- Hold rule: once ireq.valid is high, valid and addr stay stable until the cycle in which iresp.data_ok is high.
  - Count cannot rise while a request is pending, because pushes come only from data_ok.
- Push:
  - Condition: FETCH && ireq.valid && data_ok && !redirect.
  - Write {fetch_pc, iresp.data, 1} at tail; tail+1; fetch_pc += 4 (64-bit wrap).
- Pop:
  - Condition: out_valid && out_ready && !redirect.
  - head+1.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: −1.
- Redirect (highest priority, overrides push and pop):
  - head = tail = 0, count = 0, fetch_pc = redirect_pc.
  - If ireq.valid && !data_ok in that cycle: discard_addr = current ireq.addr; state → DISCARD.
  - If data_ok in that cycle: the data is dropped; state → FETCH.
- In DISCARD:
  - On data_ok: drop the data; state → FETCH.
  - A redirect while in DISCARD updates fetch_pc only and stays in DISCARD.
- imem_wait = ireq.valid && !iresp.data_ok && (count == 0), evaluated in FETCH.
  - In DISCARD, imem_wait = 1 when count == 0.
- out_valid = (count != 0); out_data is the entry at head. When empty, out_data = '0.

## Timing
- Reset values, on the first edge with reset==0:
  - state = FETCH, fetch_pc = RESET_PC, count = 0, head = tail = 0.
  - Outputs: out_valid = 0, out_data = '0, imem_wait = 0.
  - While reset is low, ireq is forced to '0.
- The cycle after reset deasserts: ireq.valid = 1 with addr = RESET_PC.
- Fetch latency: data_ok sampled at edge N → out_valid = 1 with that instruction in cycle N+1.
  - ireq.addr = fetch_pc+4 in cycle N+1 if room remains.
- Throughput: one instruction per cycle when the bus answers data_ok in the request cycle and decode pops every cycle.
- Full (count == DEPTH): ireq.valid = 0. A pop at edge N re-enables the request in cycle N+1.
- Redirect sampled at edge N:
  - out_valid = 0 in cycle N+1.
  - ireq.addr = redirect_pc in cycle N+1, unless the block entered DISCARD.
  - If in DISCARD, the first new request appears the cycle after the discarded data_ok.
- Reset mid-operation (including mid-DISCARD) abandons all state immediately. No discard tracking survives reset.

## Test plan
- Zero-wait bus, out_ready=1, reset released:
  - ireq.addr steps 0x8000_0000, _0004, _0008…
  - out_data.pc follows one cycle behind.
  - count stays ≤1.
- out_ready=0, DEPTH=4:
  - Exactly 4 pushes, then count=4 and ireq.valid=0.
  - Raising out_ready for one cycle pops pc 0x8000_0000.
  - ireq.valid returns with addr 0x8000_0010 the next cycle.
- Bus with 3-cycle data_ok latency:
  - ireq.addr is held stable for all 3 cycles.
  - imem_wait=1 while count==0.
- Redirect to 0x8000_1000 with 2 entries queued and no request pending:
  - Next cycle: count=0, out_valid=0, ireq.addr=0x8000_1000.
- Redirect while a request to 0x8000_0008 is pending:
  - ireq.addr stays 0x8000_0008 until data_ok; that data never appears at out_data.
  - Next request addr is 0x8000_1000.
  - A second redirect to 0x8000_2000 during DISCARD makes the next request 0x8000_2000.
- redirect_pc=0:
  - ireq.valid stays 0 and count stays 0 until the next redirect.
